// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode encoding, default
// highest legal opcode, sequencer state encoding and an opcode check helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6
    } alu_op_e;

    localparam int OP_MAX_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_e;

    // An opcode may be issued to the ALU only up to the configured maximum.
    function automatic logic op_legal(input logic [3:0] uc, input logic [3:0] op_max);
        return (uc <= op_max);
    endfunction

endpackage

// File: rtl/alu_sequencer_module.sv
// ALU sequencer: accepts one operation, drives a neighbouring combinational
// ALU through registered operand/opcode outputs, waits one settle cycle,
// captures the result and holds it until the consumer takes it.
// Optional feature macro ALU_SWEEP_EN: an accept with in_sweep=1 issues every
// opcode 0..OP_MAX on the same operands; without it in_sweep is ignored and
// out_last is tied to 1.
module alu_sequencer_module
    import alu_pkg::*;
#(
    parameter int OP_MAX = OP_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [3:0] in_uc,
    input  logic       in_sweep,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_uc,
    input  logic [3:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic [3:0] out_flags,
    output logic [3:0] out_uc,
    output logic       out_err,
    output logic       out_last
);

    localparam logic [3:0] OP_MAX_U = 4'(OP_MAX);

`ifdef ALU_SWEEP_EN
    localparam logic SWEEP_EN = 1'b1;
`else
    localparam logic SWEEP_EN = 1'b0;
`endif

    seq_state_e state_r;
    seq_state_e state_nxt_s;

    logic accept_s;
    logic capture_s;
    logic advance_s;
    logic release_s;
    logic sweep_req_s;
    logic sweep_r;
    logic err_pend_r;

    assign sweep_req_s = SWEEP_EN & in_sweep;

    // State register; reset returns to IDLE and abandons any pending work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and one-cycle datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        advance_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                capture_s   = 1'b1;
                state_nxt_s = ST_HOLD;
            end
            ST_HOLD: begin
                // out_valid is always set in HOLD, so out_ready alone completes the handshake.
                if (out_ready) begin
                    if (sweep_r && (alu_uc < OP_MAX_U)) begin
                        advance_s   = 1'b1;
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        release_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // in_ready is registered from the next state so it is high exactly in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (state_nxt_s == ST_IDLE);
        end
    end

    // ALU drive registers: operands load on accept, opcode steps during a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_uc     <= 4'd0;
            err_pend_r <= 1'b0;
            sweep_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                alu_a <= in_a;
                alu_b <= in_b;
                if (sweep_req_s) begin
                    alu_uc     <= 4'd0;
                    err_pend_r <= 1'b0;
                    sweep_r    <= 1'b1;
                end else if (op_legal(in_uc, OP_MAX_U)) begin
                    alu_uc     <= in_uc;
                    err_pend_r <= 1'b0;
                    sweep_r    <= 1'b0;
                end else begin
                    // Illegal opcodes never reach the ALU; the error is reported instead.
                    alu_uc     <= 4'd0;
                    err_pend_r <= 1'b1;
                    sweep_r    <= 1'b0;
                end
            end
            if (advance_s) begin
                alu_uc <= alu_uc + 4'd1;
            end
            if (release_s) begin
                sweep_r <= 1'b0;
            end
        end
    end

    // Result capture at the end of SETTLE and release on the output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 4'd0;
            out_flags  <= 4'd0;
            out_uc     <= 4'd0;
            out_err    <= 1'b0;
        end else begin
            if (capture_s) begin
                out_valid  <= 1'b1;
                out_uc     <= alu_uc;
                out_err    <= err_pend_r;
                out_result <= err_pend_r ? 4'd0 : alu_result;
                out_flags  <= err_pend_r ? 4'd0 : alu_flags;
            end
            if (advance_s || release_s) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SWEEP_EN
    // Last-result marker: single operations are always last, a sweep only at OP_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_last <= 1'b0;
        end else if (capture_s) begin
            out_last <= (~sweep_r) | (alu_uc == OP_MAX_U);
        end
    end
`else
    assign out_last = 1'b1;
`endif

endmodule
